pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: FSM encoding, cp0bubble and md_start codes,
// mult/div latencies and the bundle of front-end control strobes.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MD_BUSY = 2'd1;
  localparam logic [1:0] ST_EXC1    = 2'd2;
  localparam logic [1:0] ST_EXC2    = 2'd3;

  localparam logic [1:0] CP0_RUN    = 2'd0;
  localparam logic [1:0] CP0_FLUSH  = 2'd1;
  localparam logic [1:0] CP0_FREEZE = 2'd2;

  localparam logic [1:0] MD_NONE = 2'd0;
  localparam logic [1:0] MD_MULT = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_RSVD = 2'd3;

  localparam logic [1:0] MEMTOREG_LOAD = 2'd1;

  localparam int MULT_CYC = 4;
  localparam int DIV_CYC  = 32;

  typedef struct packed {
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] cp0bubble;
  } ctrl_t;

  // Counter preload: the counter runs down to zero, so it starts at latency-1.
  function automatic logic [4:0] md_load(input logic [1:0] start);
    case (start)
      MD_MULT: return 5'(MULT_CYC - 1);
      MD_DIV:  return 5'(DIV_CYC - 1);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: the ID instruction reads a register that the
// load currently in EX has not yet fetched from memory.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // Register $0 is never a real dependency, so ex_rw==0 is excluded.
  always_comb begin
    rs_hit   = id_uses_rs && (id_rs == ex_rw);
    rt_hit   = id_uses_rt && (id_rt == ex_rw);
    load_use = (ex_memtoreg == MEMTOREG_LOAD) && ex_regWr && (ex_rw != 5'd0)
               && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use stall, multi-cycle mult/div busy tracking and the
// two-cycle CP0 exception flush sequence.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_md_op,
  input  logic       id_hilo_rd,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  input  logic [1:0] ex_md_start,
  input  logic       exc_req,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] cp0bubble,
  output logic       md_busy,
  output logic       md_done,
  output logic [4:0] md_cnt
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [4:0] cnt;
  logic [4:0] cnt_next;
  logic       load_use;
  logic       in_busy;
  ctrl_t      ctrl;

  hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rw       (ex_rw),
    .ex_regWr    (ex_regWr),
    .ex_memtoreg (ex_memtoreg),
    .load_use    (load_use)
  );

  assign in_busy = (state == ST_MD_BUSY);

  // An exception always wins and abandons any mult/div in flight.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (exc_req) begin
      state_next = ST_EXC1;
      cnt_next   = 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_md_start == MD_MULT || ex_md_start == MD_DIV) begin
            state_next = ST_MD_BUSY;
            cnt_next   = md_load(ex_md_start);
          end
        end
        ST_MD_BUSY: begin
          if (cnt == 5'd0) state_next = ST_IDLE;
          else             cnt_next   = cnt - 5'd1;
        end
        ST_EXC1: state_next = ST_EXC2;
        ST_EXC2: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The exc_req cycle itself only suppresses stalls; the flush happens in EXC1/EXC2.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (state == ST_EXC1) begin
        ctrl.cp0bubble   = CP0_FREEZE;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end else if (state == ST_EXC2) begin
        ctrl.cp0bubble   = CP0_FLUSH;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end else if (exc_req) begin
        ctrl = '0;
      end else if ((in_busy && (id_md_op || id_hilo_rd)) || load_use) begin
        ctrl.pc_stall    = 1'b1;
        ctrl.ifid_stall  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign cp0bubble   = ctrl.cp0bubble;
  assign md_busy     = !rst && in_busy;
  assign md_done     = !rst && in_busy && (cnt == 5'd0) && !exc_req;
  assign md_cnt      = rst ? 5'd0 : cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a cycle-count reference model.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic       id_uses_rs, id_uses_rt, id_md_op, id_hilo_rd, ex_regWr, exc_req;
  logic [1:0] ex_memtoreg, ex_md_start;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, md_busy, md_done;
  logic [1:0] cp0bubble;
  logic [4:0] md_cnt;
  logic [12:0] obs;

  int checks;
  int failures;
  int m_busy_left;
  int m_exc;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_md_op    (id_md_op),
    .id_hilo_rd  (id_hilo_rd),
    .ex_rw       (ex_rw),
    .ex_regWr    (ex_regWr),
    .ex_memtoreg (ex_memtoreg),
    .ex_md_start (ex_md_start),
    .exc_req     (exc_req),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .cp0bubble   (cp0bubble),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_cnt      (md_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, cp0bubble, md_busy, md_done, md_cnt};

  function automatic logic [12:0] outs(input logic pc, input logic fs, input logic fl,
                                       input logic bb, input logic [1:0] cp0,
                                       input logic bsy, input logic dn, input logic [4:0] c);
    return {pc, fs, fl, bb, cp0, bsy, dn, c};
  endfunction

  // Reference model: busy is tracked as "cycles of busy left", exceptions as a phase number.
  function automatic logic [12:0] model_outputs();
    logic       lu;
    logic       busy;
    logic       done;
    logic [4:0] c;
    lu = (ex_memtoreg == 2'd1) && ex_regWr && (ex_rw != 5'd0) &&
         ((id_uses_rs && id_rs == ex_rw) || (id_uses_rt && id_rt == ex_rw));
    if (rst) return '0;
    busy = (m_busy_left > 0);
    c    = busy ? 5'(m_busy_left - 1) : 5'd0;
    done = busy && (m_busy_left == 1) && !exc_req;
    if (m_exc == 1) return outs(0, 0, 1, 1, 2'd2, busy, done, c);
    if (m_exc == 2) return outs(0, 0, 1, 1, 2'd1, busy, done, c);
    if (exc_req)    return outs(0, 0, 0, 0, 2'd0, busy, 0, c);
    if ((busy && (id_md_op || id_hilo_rd)) || lu) return outs(1, 1, 0, 1, 2'd0, busy, done, c);
    return outs(0, 0, 0, 0, 2'd0, busy, done, c);
  endfunction

  task automatic model_tick();
    if (rst) begin
      m_busy_left = 0;
      m_exc       = 0;
    end else if (exc_req) begin
      m_exc       = 1;
      m_busy_left = 0;
    end else if (m_exc == 1) m_exc = 2;
    else if (m_exc == 2) m_exc = 0;
    else if (m_busy_left > 0) m_busy_left--;
    else if (ex_md_start == 2'd1) m_busy_left = 4;
    else if (ex_md_start == 2'd2) m_busy_left = 32;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; id_rs = 0; id_rt = 0; ex_rw = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_md_op = 0; id_hilo_rd = 0; ex_regWr = 0; exc_req = 0; ex_memtoreg = 0; ex_md_start = 0;
  endtask

  task automatic set_load_use();
    ex_memtoreg = 2'd1; ex_regWr = 1; ex_rw = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; exc_req = 1; ex_md_start = 2'd1; id_hilo_rd = 1;
    set_load_use();
    #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL reset_hold0: got %b expected %b", obs, 13'd0); end
    next_cycle(); #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL reset_hold1: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs(); #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL reset_release: got %b expected %b", obs, 13'd0); end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [12:0] stall;
    stall = outs(1, 1, 0, 1, 2'd0, 0, 0, 5'd0);
    clear_inputs(); set_load_use(); #2; checks++;
    if (obs !== stall) begin failures++; $display("[TB] FAIL load_use_rs: got %b expected %b", obs, stall); end
    next_cycle(); clear_inputs(); #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL load_use_release: got %b expected %b", obs, 13'd0); end
    ex_memtoreg = 2'd1; ex_regWr = 1; ex_rw = 5'd9; id_rt = 5'd9; id_uses_rt = 1; #2; checks++;
    if (obs !== stall) begin failures++; $display("[TB] FAIL load_use_rt: got %b expected %b", obs, stall); end
    next_cycle(); clear_inputs();
    set_load_use(); ex_rw = 5'd0; id_rs = 5'd0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL load_use_r0: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs();
    set_load_use(); ex_memtoreg = 2'd2; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL load_use_notload: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs();
    set_load_use(); id_uses_rs = 0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL load_use_unused: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_mult();
    logic [12:0] exp;
    clear_inputs(); ex_md_start = 2'd1; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL mult_start: got %b expected %b", obs, 13'd0); end
    next_cycle(); ex_md_start = 2'd0; id_hilo_rd = 1;
    for (int i = 0; i < 4; i++) begin
      exp = outs(1, 1, 0, 1, 2'd0, 1, (i == 3), 5'(3 - i));
      #2; checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL mult_cycle%0d: got %b expected %b", i, obs, exp); end
      next_cycle();
    end
    #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL mult_release: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_div();
    logic [12:0] exp;
    int dones;
    dones = 0;
    clear_inputs(); ex_md_start = 2'd2;
    next_cycle(); ex_md_start = 2'd0;
    id_uses_rs = 1; id_rs = 5'd3; id_uses_rt = 1; id_rt = 5'd4;
    for (int i = 0; i < 32; i++) begin
      exp = outs(0, 0, 0, 0, 2'd0, 1, (i == 31), 5'(31 - i));
      #2; checks++;
      if (md_done) dones++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL div_cycle%0d: got %b expected %b", i, obs, exp); end
      next_cycle();
    end
    #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL div_after: got %b expected %b", obs, 13'd0); end
    checks++;
    if (dones !== 1) begin failures++; $display("[TB] FAIL div_done_pulses: got %0d expected 1", dones); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_exc_during_div();
    logic [12:0] exp;
    clear_inputs(); ex_md_start = 2'd2;
    next_cycle(); ex_md_start = 2'd0;
    for (int i = 0; i < 21; i++) next_cycle();
    exc_req = 1;
    exp = outs(0, 0, 0, 0, 2'd0, 1, 0, 5'd10); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_div_req: got %b expected %b", obs, exp); end
    next_cycle(); exc_req = 0;
    exp = outs(0, 0, 1, 1, 2'd2, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_div_exc1: got %b expected %b", obs, exp); end
    next_cycle();
    exp = outs(0, 0, 1, 1, 2'd1, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_div_exc2: got %b expected %b", obs, exp); end
    for (int i = 0; i < 12; i++) begin
      next_cycle(); #2; checks++;
      if (obs !== '0) begin failures++; $display("[TB] FAIL exc_div_idle%0d: got %b expected %b", i, obs, 13'd0); end
    end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    clear_inputs(); ex_md_start = 2'd2;
    next_cycle(); ex_md_start = 2'd0;
    for (int i = 0; i < 5; i++) next_cycle();
    rst = 1; id_hilo_rd = 1; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL rst_busy_same: got %b expected %b", obs, 13'd0); end
    next_cycle(); rst = 0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL rst_busy_after: got %b expected %b", obs, 13'd0); end
    next_cycle(); clear_inputs(); exc_req = 1;
    next_cycle(); exc_req = 0; rst = 1; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL rst_exc1_same: got %b expected %b", obs, 13'd0); end
    next_cycle(); rst = 0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL rst_exc1_after: got %b expected %b", obs, 13'd0); end
    next_cycle();
  endtask

  task automatic test_exc_load_use();
    logic [12:0] exp;
    clear_inputs(); set_load_use(); exc_req = 1; #2; checks++;
    if (pc_stall !== 1'b0) begin failures++; $display("[TB] FAIL exc_lu_req_pc: got %b expected 0", pc_stall); end
    next_cycle(); exc_req = 0;
    exp = outs(0, 0, 1, 1, 2'd2, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_lu_exc1: got %b expected %b", obs, exp); end
    next_cycle();
    exp = outs(0, 0, 1, 1, 2'd1, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_lu_exc2: got %b expected %b", obs, exp); end
    next_cycle();
    exp = outs(1, 1, 0, 1, 2'd0, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_lu_resume: got %b expected %b", obs, exp); end
    next_cycle(); clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    clear_inputs(); ex_md_start = 2'd3;
    next_cycle(); ex_md_start = 2'd0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL md_reserved: got %b expected %b", obs, 13'd0); end
    ex_md_start = 2'd1;
    next_cycle(); ex_md_start = 2'd2;
    for (int i = 0; i < 4; i++) begin
      exp = outs(0, 0, 0, 0, 2'd0, 1, (i == 3), 5'(3 - i));
      #2; checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL md_restart_ignored%0d: got %b expected %b", i, obs, exp); end
      next_cycle();
    end
    ex_md_start = 2'd0; #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL md_b2b_idle: got %b expected %b", obs, 13'd0); end
    exc_req = 1;
    next_cycle();
    exp = outs(0, 0, 1, 1, 2'd2, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_restart_a: got %b expected %b", obs, exp); end
    next_cycle(); exc_req = 0; #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_restart_b: got %b expected %b", obs, exp); end
    next_cycle();
    exp = outs(0, 0, 1, 1, 2'd1, 0, 0, 5'd0); #2; checks++;
    if (obs !== exp) begin failures++; $display("[TB] FAIL exc_restart_c: got %b expected %b", obs, exp); end
    next_cycle(); #2; checks++;
    if (obs !== '0) begin failures++; $display("[TB] FAIL exc_restart_idle: got %b expected %b", obs, 13'd0); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [12:0] exp;
    m_busy_left = 0;
    m_exc       = 0;
    for (int n = 0; n < 3000; n++) begin
      rst         = (n == 0) || ($urandom_range(0, 199) == 0);
      exc_req     = ($urandom_range(0, 39) == 0);
      ex_md_start = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rw       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom);
      id_uses_rt  = 1'($urandom);
      ex_regWr    = 1'($urandom);
      ex_memtoreg = 2'($urandom_range(0, 3));
      id_md_op    = ($urandom_range(0, 3) == 0);
      id_hilo_rd  = ($urandom_range(0, 3) == 0);
      #2;
      exp = model_outputs();
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL random_%0d: got %b expected %b", n, obs, exp); end
      checks++;
      if (pc_stall && ifid_flush) begin failures++; $display("[TB] FAIL random_excl_%0d: got pc_stall=1 ifid_flush=1 expected not both", n); end
      model_tick();
      next_cycle();
    end
    clear_inputs(); rst = 1;
    next_cycle(); rst = 0;
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst = 1;
    test_reset();
    test_load_use();
    test_mult();
    test_div();
    test_exc_during_div();
    test_reset_inflight();
    test_exc_load_use();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
